// File: rtl/keypad_pkg.sv
// Shared keypad types and constants: scanner FSM states, matrix size,
// and key codes that the setpoint logic recognises.
package keypad_pkg;

    localparam int COLS = 4;
    localparam int ROWS = 4;

    localparam logic [3:0] KEY_STAR = 4'hC;
    localparam logic [3:0] KEY_HASH = 4'hE;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    // Several rows pressed at once resolve to the lowest-index active row.
    function automatic logic [1:0] lowest_row(input logic [3:0] pat);
        lowest_row = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!pat[i]) lowest_row = 2'(i);
        end
    endfunction

endpackage

// File: rtl/divisor_varredura.sv
// Scan-rate divider: one-cycle tick every CLK_DIV system clocks.
module divisor_varredura #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad reader: column scan, row synchronizer, press/release
// debounce, and a valid/ack hand-off of each accepted key code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV  = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] linha_tec,
    output logic [3:0] coluna_tec,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       overrun,
    output state_t     dbg_state
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          tick;
    logic [3:0]    sync1, rs;
    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    col, col_d;
    logic [3:0]    pat, pat_d;
    logic          accept;
    logic [3:0]    new_code;

    divisor_varredura #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 4'hF;
            rs    <= 4'hF;
        end else begin
            sync1 <= linha_tec;
            rs    <= sync1;
        end
    end

    // The SCAN tick that finds a pressed row is the first matching sample.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        col_d   = col;
        pat_d   = pat;
        accept  = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (rs == 4'hF) begin
                        col_d = col + 2'd1;
                    end else begin
                        pat_d = rs;
                        cnt_d = CW'(1);
                        if (DEBOUNCE <= 1) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (rs != pat) begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt + CW'(1);
                        if (int'(cnt) + 1 >= DEBOUNCE) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end
                    end
                end
                HELD: begin
                    if (rs == 4'hF) begin
                        cnt_d = CW'(1);
                        if (DEBOUNCE <= 1) begin
                            state_d = SCAN;
                            col_d   = col + 2'd1;
                        end else begin
                            state_d = DEB_REL;
                        end
                    end
                end
                DEB_REL: begin
                    if (rs != 4'hF) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt + CW'(1);
                        if (int'(cnt) + 1 >= DEBOUNCE) begin
                            cnt_d   = '0;
                            state_d = SCAN;
                            col_d   = col + 2'd1;
                        end
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SCAN;
            cnt        <= '0;
            col        <= 2'd0;
            pat        <= 4'hF;
            coluna_tec <= 4'b1110;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            col        <= col_d;
            pat        <= pat_d;
            coluna_tec <= ~(4'b0001 << col_d);
        end
    end

    assign new_code = {lowest_row(pat_d), col};

    // Handshake: key_valid holds key_code until key_ack is sampled high; it
    // drops the next cycle. A key accepted while valid and unacked is dropped
    // and flags overrun; an ack in the accepting cycle lets the new key load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (key_ack) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
            if (accept) begin
                if (!key_valid || key_ack) begin
                    key_code  <= new_code;
                    key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a pressed-key matrix model.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int DEBOUNCE = 3;

    logic       clk;
    logic       reset;
    logic [3:0] linha_tec;
    logic [3:0] coluna_tec;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       overrun;
    state_t     dbg_state;

    int checks = 0;
    int passes = 0;

    logic       pressed [4][4];
    logic [3:0] rows_model;
    logic [3:0] exp_q[$];

    keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk        (clk),
        .reset      (reset),
        .linha_tec  (linha_tec),
        .coluna_tec (coluna_tec),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ack    (key_ack),
        .overrun    (overrun),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows_model = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r][c] && !coluna_tec[c]) rows_model[r] = 1'b0;
            end
        end
    end
    assign linha_tec = rows_model;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pressed[r][c] = 1'b0;
    endtask

    task automatic press(input int r, input int c);
        pressed[r][c] = 1'b1;
    endtask

    task automatic do_reset();
        key_ack = 1'b0;
        release_all();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        step();
        key_ack = 1'b0;
    endtask

    task automatic wait_state(input state_t s, input string name);
        int n = 0;
        while (dbg_state != s && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (dbg_state != s) $display("FAIL %s: timeout waiting state, got %0d expected %0d", name, dbg_state, s);
        else passes++;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (key_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (key_valid !== 1'b1) $display("FAIL %s: timeout waiting key_valid, got %b expected 1", name, key_valid);
        else passes++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        key_ack = 1'b0;
        release_all();
        reset = 1'b0;
        repeat (2) step();
        checks++;
        if (coluna_tec !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || overrun !== 1'b0 || dbg_state !== SCAN)
            $display("FAIL reset_values: got col=%b code=%h v=%b ovr=%b st=%0d expected col=1110 code=0 v=0 ovr=0 st=0",
                     coluna_tec, key_code, key_valid, overrun, dbg_state);
        else passes++;
        reset = 1'b1;
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_col;
        int n = 0;
        bit held_ok;
        do_reset();
        while (coluna_tec === 4'b1110 && n < 20) begin
            step();
            n++;
        end
        exp_col = 4'b1101;
        for (int k = 0; k < 8; k++) begin
            held_ok = 1'b1;
            for (int j = 0; j < CLK_DIV; j++) begin
                if (coluna_tec !== exp_col) held_ok = 1'b0;
                step();
            end
            checks++;
            if (!held_ok) $display("FAIL idle_col_step%0d: got %b expected %b held %0d clocks", k, coluna_tec, exp_col, CLK_DIV);
            else passes++;
            exp_col = {exp_col[2:0], exp_col[3]};
        end
        checks++;
        if (key_valid !== 1'b0) $display("FAIL idle_valid: got %b expected 0", key_valid);
        else passes++;
    endtask

    task automatic test_clean_press();
        int n = 0;
        do_reset();
        press(2, 1);
        wait_state(DEB_PRESS, "clean_enter_deb");
        while (key_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n != (DEBOUNCE - 1) * CLK_DIV) $display("FAIL clean_latency: got %0d clocks expected %0d", n, (DEBOUNCE - 1) * CLK_DIV);
        else passes++;
        checks++;
        if (key_code !== 4'h9) $display("FAIL clean_code: got %h expected 9", key_code);
        else passes++;
        repeat (40) step();
        checks++;
        if (key_valid !== 1'b1 || overrun !== 1'b0 || key_code !== 4'h9)
            $display("FAIL clean_single_accept: got v=%b ovr=%b code=%h expected v=1 ovr=0 code=9", key_valid, overrun, key_code);
        else passes++;
        release_all();
        wait_state(SCAN, "clean_release");
        checks++;
        if (coluna_tec !== 4'b1011) $display("FAIL clean_col_advance: got %b expected 1011", coluna_tec);
        else passes++;
        ack_pulse();
        checks++;
        if (key_valid !== 1'b0) $display("FAIL clean_ack: got %b expected 0", key_valid);
        else passes++;
    endtask

    task automatic test_bounce();
        bit stayed_low = 1'b1;
        do_reset();
        press(2, 1);
        wait_state(DEB_PRESS, "bounce_enter_deb");
        release_all();
        for (int i = 0; i < 12; i++) begin
            if (key_valid !== 1'b0) stayed_low = 1'b0;
            step();
        end
        checks++;
        if (!stayed_low || dbg_state !== SCAN)
            $display("FAIL bounce_abort: got valid_low=%b st=%0d expected 1 and %0d", stayed_low, dbg_state, SCAN);
        else passes++;
        press(2, 1);
        wait_valid("bounce_retry");
        checks++;
        if (key_code !== 4'h9) $display("FAIL bounce_code: got %h expected 9", key_code);
        else passes++;
        release_all();
        wait_state(SCAN, "bounce_release");
        ack_pulse();
    endtask

    task automatic test_two_keys();
        int n = 0;
        do_reset();
        press(0, 0);
        wait_valid("two_first");
        checks++;
        if (key_code !== 4'h0) $display("FAIL two_first_code: got %h expected 0", key_code);
        else passes++;
        release_all();
        wait_state(SCAN, "two_release1");
        press(1, 3);
        while (overrun !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (overrun !== 1'b1 || key_code !== 4'h0 || key_valid !== 1'b1)
            $display("FAIL two_overrun: got ovr=%b code=%h v=%b expected ovr=1 code=0 v=1", overrun, key_code, key_valid);
        else passes++;
        release_all();
        wait_state(SCAN, "two_release2");
        ack_pulse();
        checks++;
        if (key_valid !== 1'b0 || overrun !== 1'b0)
            $display("FAIL two_ack_clear: got v=%b ovr=%b expected 0 0", key_valid, overrun);
        else passes++;
    endtask

    task automatic test_multi_row();
        do_reset();
        press(1, 2);
        press(3, 2);
        wait_valid("multi_valid");
        checks++;
        if (key_code !== 4'h6) $display("FAIL multi_row_code: got %h expected 6", key_code);
        else passes++;
        release_all();
        wait_state(SCAN, "multi_release");
        ack_pulse();
    endtask

    task automatic test_reset_mid_debounce();
        bit held_ok = 1'b1;
        do_reset();
        press(2, 3);
        wait_valid("rst_prior_key");
        release_all();
        wait_state(SCAN, "rst_prior_release");
        press(0, 1);
        wait_state(DEB_PRESS, "rst_enter_deb");
        reset = 1'b0;
        #1;
        checks++;
        if (coluna_tec !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || overrun !== 1'b0 || dbg_state !== SCAN)
            $display("FAIL reset_async: got col=%b code=%h v=%b ovr=%b st=%0d expected col=1110 code=0 v=0 ovr=0 st=0",
                     coluna_tec, key_code, key_valid, overrun, dbg_state);
        else passes++;
        release_all();
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < CLK_DIV - 1; i++) begin
            step();
            if (coluna_tec !== 4'b1110) held_ok = 1'b0;
        end
        step();
        checks++;
        if (!held_ok || coluna_tec !== 4'b1101)
            $display("FAIL reset_restart_col: got held=%b col=%b expected held=1 col=1101", held_ok, coluna_tec);
        else passes++;
    endtask

    task automatic test_random_keys();
        int r, c;
        logic [3:0] exp_code;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            exp_q.push_back(4'(r * 4 + c));
            press(r, c);
            wait_valid("rand_valid");
            exp_code = exp_q.pop_front();
            checks++;
            if (key_code !== exp_code || overrun !== 1'b0)
                $display("FAIL rand_key%0d: got code=%h ovr=%b expected code=%h ovr=0", k, key_code, overrun, exp_code);
            else passes++;
            repeat ($urandom_range(0, 5)) step();
            ack_pulse();
            repeat ($urandom_range(0, 10)) step();
            release_all();
            wait_state(SCAN, "rand_release");
            checks++;
            if (key_valid !== 1'b0) $display("FAIL rand_no_repeat%0d: got %b expected 0", k, key_valid);
            else passes++;
            repeat ($urandom_range(0, 20)) step();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset   = 1'b0;
        key_ack = 1'b0;
        release_all();
        test_reset();
        test_idle_scan();
        test_clean_press();
        test_bounce();
        test_two_keys();
        test_multi_row();
        test_reset_mid_debounce();
        test_random_keys();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
